// File: rtl/velo_descrambler_param.sv
// velo_descrambler_param
// Self-synchronising frame descrambler for the VELO receive path. Each
// accepted frame is descrambled against the previous descrambled frame
// using a programmable tap set. The block also has a bypass mode, a
// priming/sync FSM, a synchronous resync and a saturating frame counter.
module velo_descrambler_param #(
  parameter int unsigned WIDTH       = 30,
  // Bit k-1 set means a tap at delay k. The mask is 64 bits wide so that
  // taps above the frame width are rejected at elaboration.
  parameter logic [63:0] TAP_MASK    = 64'h0000_0000_3000_6000,
  // Alternating 1010...10 pattern, MSB = 1, taken from the top of a 64-bit pattern.
  parameter logic [WIDTH-1:0] INIT   = WIDTH'({32{2'b10}} >> (64 - WIDTH)),
  parameter int unsigned SYNC_FRAMES = 1
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             resync_i,
  input  logic             in_valid_i,
  input  logic             descramble_en_i,
  input  logic [WIDTH-1:0] frame_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             synced_o,
  output logic [15:0]      frame_cnt_o
);

  localparam int unsigned W_SYNC = 4;
  localparam int unsigned W_CNT  = 16;
  localparam int unsigned W_X    = 2 * WIDTH;
  localparam logic [W_SYNC-1:0] SYNC_LAST = W_SYNC'(SYNC_FRAMES - 1);
  localparam logic [W_CNT-1:0]  CNT_MAX   = {W_CNT{1'b1}};

  // Reject parameter sets that cannot describe a valid descrambler.
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("velo_descrambler_param: WIDTH must be in 8..64");
  end
  if (TAP_MASK == 64'd0) begin : g_bad_mask_zero
    $error("velo_descrambler_param: TAP_MASK must have at least one tap");
  end
  if (WIDTH < 64) begin : g_mask_range
    if ((TAP_MASK >> WIDTH) != 64'd0) begin : g_bad_mask_range
      $error("velo_descrambler_param: TAP_MASK has a tap deeper than WIDTH");
    end
  end
  if (SYNC_FRAMES < 1 || SYNC_FRAMES > 15) begin : g_bad_sync
    $error("velo_descrambler_param: SYNC_FRAMES must be in 1..15");
  end

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_hist;
  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic [W_SYNC-1:0]   r_sync_cnt;
  logic [W_CNT-1:0]    r_frame_cnt;
  logic [W_X-1:0]      w_x;
  logic [WIDTH-1:0]    w_desc;
  logic                w_accept;
  logic                w_desc_accept;
  logic                w_synced;

  // A frame is accepted only when no resync is requested in the same cycle.
  assign w_accept      = in_valid_i & ~resync_i;
  assign w_desc_accept = w_accept & descramble_en_i;

  // Combinational XOR tree over the concatenated {frame, history} window.
  always_comb begin
    w_x    = {frame_i, r_hist};
    w_desc = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      logic v_bit;
      v_bit = frame_i[i];
      for (int k = 1; k <= int'(WIDTH); k++) begin
        if (TAP_MASK[k-1]) begin
          v_bit = v_bit ^ w_x[int'(WIDTH) + i - k];
        end
      end
      w_desc[i] = v_bit;
    end
  end

  // Datapath: output frame, valid pulse and descrambler history.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_hist  <= INIT;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (resync_i) begin
      r_hist  <= INIT;
      r_valid <= 1'b0;
    end else if (in_valid_i) begin
      r_valid <= 1'b1;
      if (descramble_en_i) begin
        r_data <= w_desc;
        r_hist <= frame_i;
      end else begin
        r_data <= frame_i;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Priming counter: counts descrambled frames while the history fills.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_sync_cnt <= '0;
    end else if (resync_i) begin
      r_sync_cnt <= '0;
    end else if (w_desc_accept && (r_state == ST_PRIME)) begin
      r_sync_cnt <= r_sync_cnt + W_SYNC'(1);
    end
  end

  // Saturating count of output frames; resync does not clear it.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_accept && (r_frame_cnt != CNT_MAX)) begin
      r_frame_cnt <= r_frame_cnt + W_CNT'(1);
    end
  end

  // Sync FSM state register.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sync FSM next state: leave PRIME on the last priming frame.
  always_comb begin
    w_state_nxt = r_state;
    if (resync_i) begin
      w_state_nxt = ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (w_desc_accept && (r_sync_cnt == SYNC_LAST)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN:   w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_PRIME;
      endcase
    end
  end

  // Sync FSM output: synced is a direct decode of the state flop.
  always_comb begin
    w_synced = 1'b0;
    case (r_state)
      ST_RUN:  w_synced = 1'b1;
      default: w_synced = 1'b0;
    endcase
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign synced_o    = w_synced;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_velo_descrambler_param.sv
// Scoreboard bench for velo_descrambler_param: a default 30-bit instance and
// a 16-bit instance (taps at delays 3 and 16, three priming frames).
module tb_velo_descrambler_param;

  localparam int unsigned W0 = 30;
  localparam int unsigned W1 = 16;
  localparam logic [63:0] MASK0 = 64'h3000_6000;
  localparam logic [63:0] MASK1 = 64'h8004;
  localparam logic [63:0] INIT0 = 64'h2AAA_AAAA;
  localparam logic [63:0] INIT1 = 64'hAAAA;
  localparam logic [63:0] WM0   = 64'h3FFF_FFFF;
  localparam logic [63:0] WM1   = 64'hFFFF;
  localparam int SF0 = 1;
  localparam int SF1 = 3;

  typedef struct {
    logic [63:0] data;
    logic        synced;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rs0, v0, en0;
  logic [W0-1:0] f0, d0;
  logic vo0, so0;
  logic [15:0] c0;
  logic rs1, v1, en1;
  logic [W1-1:0] f1, d1;
  logic vo1, so1;
  logic [15:0] c1;

  velo_descrambler_param u_dut0 (
    .clk_i(clk), .reset(reset), .resync_i(rs0), .in_valid_i(v0),
    .descramble_en_i(en0), .frame_i(f0), .data_o(d0), .valid_o(vo0),
    .synced_o(so0), .frame_cnt_o(c0)
  );

  velo_descrambler_param #(
    .WIDTH(16), .TAP_MASK(MASK1), .INIT(16'hAAAA), .SYNC_FRAMES(3)
  ) u_dut1 (
    .clk_i(clk), .reset(reset), .resync_i(rs1), .in_valid_i(v1),
    .descramble_en_i(en1), .frame_i(f1), .data_o(d1), .valid_o(vo1),
    .synced_o(so1), .frame_cnt_o(c1)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] m_hist [2];
  int          m_sc   [2];
  logic        m_sync [2];
  int          m_cnt  [2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference self-synchronising scrambler: s[i] = d[i] ^ taps over {s, hist}.
  function automatic logic [63:0] scramble(input logic [63:0] d, input logic [63:0] h,
                                           input logic [63:0] mask, input int w);
    logic [127:0] y;
    logic [63:0]  s;
    logic         b;
    y = '0;
    s = '0;
    for (int j = 0; j < w; j++) y[j] = h[j];
    for (int i = 0; i < w; i++) begin
      b = d[i];
      for (int k = 1; k <= w; k++) if (mask[k-1]) b = b ^ y[w + i - k];
      y[w + i] = b;
      s[i] = b;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_hist[0] = INIT0; m_hist[1] = INIT1;
    for (int d = 0; d < 2; d++) begin
      m_sc[d] = 0; m_sync[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  // Drive one cycle on instance d and push the expected response if any.
  task automatic send(input int d, input logic v, input logic en, input logic rs,
                      input logic [63:0] f, input logic [63:0] ed);
    exp_t e;
    if (d == 0) begin rs0 = rs; v0 = v; en0 = en; f0 = f[W0-1:0]; end
    else        begin rs1 = rs; v1 = v; en1 = en; f1 = f[W1-1:0]; end
    if (rs) begin
      m_hist[d] = (d == 0) ? INIT0 : INIT1;
      m_sc[d] = 0;
      m_sync[d] = 1'b0;
    end else if (v) begin
      if (en) begin
        m_hist[d] = f;
        m_sc[d]++;
        if (m_sc[d] >= ((d == 0) ? SF0 : SF1)) m_sync[d] = 1'b1;
      end
      if (m_cnt[d] < 65535) m_cnt[d]++;
      e.data = ed;
      e.synced = m_sync[d];
      e.cnt = 16'(m_cnt[d]);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (d == 0) begin v0 = 1'b0; rs0 = 1'b0; end
    else        begin v1 = 1'b0; rs1 = 1'b0; end
  endtask

  // Round trip: random data scrambled by the model must come back unchanged.
  task automatic rt(input int d, input int n);
    logic [63:0] dat, s;
    for (int i = 0; i < n; i++) begin
      dat = {$urandom, $urandom} & ((d == 0) ? WM0 : WM1);
      s = scramble(dat, m_hist[d], (d == 0) ? MASK0 : MASK1, (d == 0) ? int'(W0) : int'(W1));
      send(d, 1'b1, 1'b1, 1'b0, s, dat);
    end
  endtask

  // Monitor for instance 0.
  always @(negedge clk) begin
    if (vo0) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL dut0 unexpected valid_o: data 0x%0h, no frame expected", d0);
      end else begin
        e0 = q0.pop_front();
        check("dut0 data_o", 64'(d0), e0.data);
        check("dut0 synced_o", 64'(so0), 64'(e0.synced));
        check("dut0 frame_cnt_o", 64'(c0), 64'(e0.cnt));
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (vo1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL dut1 unexpected valid_o: data 0x%0h, no frame expected", d1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 data_o", 64'(d1), e1.data);
        check("dut1 synced_o", 64'(so1), 64'(e1.synced));
        check("dut1 frame_cnt_o", 64'(c1), 64'(e1.cnt));
      end
    end
  end

  initial begin
    logic [63:0] f;
    int sent;
    reset = 1'b1;
    rs0 = 0; v0 = 0; en0 = 0; f0 = '0;
    rs1 = 0; v1 = 0; en1 = 0; f1 = '0;
    model_reset();
    #1 reset = 1'b0;
    #11;
    check("reset dut0 data_o", 64'(d0), 64'd0);
    check("reset dut0 valid_o", 64'(vo0), 64'd0);
    check("reset dut0 synced_o", 64'(so0), 64'd0);
    check("reset dut0 frame_cnt_o", 64'(c0), 64'd0);
    check("reset dut1 data_o", 64'(d1), 64'd0);
    check("reset dut1 valid_o", 64'(vo1), 64'd0);
    check("reset dut1 synced_o", 64'(so1), 64'd0);
    check("reset dut1 frame_cnt_o", 64'(c1), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // First frames against the INIT history.
    send(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'h3FFF_8000);
    send(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0);

    rt(0, 1000);

    // Bypass does not advance history.
    send(0, 1'b1, 1'b0, 1'b0, 64'h1234_5678, 64'h1234_5678);
    rt(0, 5);

    // Generic width instance, then resync collision and re-priming.
    rt(1, 300);
    check("dut1 synced before resync", 64'(so1), 64'd1);
    send(1, 1'b1, 1'b1, 1'b1, 64'h5A5A, 64'd0);
    check("resync valid_o", 64'(vo1), 64'd0);
    check("resync synced_o", 64'(so1), 64'd0);
    check("resync frame_cnt_o", 64'(c1), 64'(m_cnt[1]));
    rt(1, 2);
    check("dut1 synced after 2 frames", 64'(so1), 64'd0);
    rt(1, 1);
    check("dut1 synced after 3 frames", 64'(so1), 64'd1);
    send(1, 1'b1, 1'b0, 1'b0, 64'h0F0F, 64'h0F0F);
    rt(1, 20);

    // Drive the frame counter to saturation with bypass frames.
    sent = 0;
    while (m_cnt[0] < 65535) begin
      f = 64'(sent) & WM0;
      send(0, 1'b1, 1'b0, 1'b0, f, f);
      sent++;
    end
    for (int i = 0; i < 3; i++) send(0, 1'b1, 1'b0, 1'b0, 64'h0ABC_DEF0, 64'h0ABC_DEF0);
    check("frame_cnt_o saturated", 64'(c0), 64'hFFFF);
    rt(0, 4);

    // Reset with a frame in flight: outputs clear at once and the frame is lost.
    v0 = 1'b1; en0 = 1'b1; f0 = 30'h1555_1234;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset data_o", 64'(d0), 64'd0);
    check("midreset valid_o", 64'(vo0), 64'd0);
    check("midreset synced_o", 64'(so0), 64'd0);
    check("midreset frame_cnt_o", 64'(c0), 64'd0);
    check("midreset dut1 frame_cnt_o", 64'(c1), 64'd0);
    v0 = 1'b0; en0 = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset no valid_o", 64'(vo0), 64'd0);
    send(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'h3FFF_8000);
    send(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
    check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/velo_descrambler_param.md
# velo_descrambler_param

Parametrised self-synchronising frame descrambler for the VELO serial link receive path. It replaces the fixed 30-bit descrambler, and sits between the frame aligner and the downstream decoder. It descrambles one WIDTH-bit frame per accepted input cycle using a programmable tap set over the previous frame. It adds an input valid qualifier, a priming/sync state machine, a synchronous resync request and a saturating output-frame counter.

## Interface
Parameters:
- WIDTH, 30: frame width in bits, 8..64.
- TAP_MASK, bits 13, 14, 28, 29 set (delays 14, 15, 29, 30): WIDTH-bit mask. Bit k-1 set means a tap at delay k bits; the maximum delay is WIDTH.
- INIT, alternating pattern 1010…10 (MSB = 1, LSB = 0; 0x2AAAAAAA at WIDTH = 30): history value loaded on reset and on resync.
- SYNC_FRAMES, 1: number of descrambled frames consumed before synced_o asserts, 1..15.

Ports:
- clk_i, input, 1: clock; all registers update on the rising edge.
- reset, input, 1: reset, asynchronous, active-low.
- resync_i, input, 1: synchronous pulse; re-initialises history and sync state.
- in_valid_i, input, 1: frame_i is valid this cycle.
- descramble_en_i, input, 1: 1 descrambles the frame; 0 passes it through (bypass).
- frame_i, input, WIDTH: scrambled frame. Bit 0 is the oldest bit.
- data_o, output, WIDTH: registered output frame.
- valid_o, output, 1: data_o is valid; a one-cycle pulse per accepted frame.
- synced_o, output, 1: the descrambler history is fully primed.
- frame_cnt_o, output, 16: count of valid_o pulses since reset, saturating.

## Operation
- **History register.** hist holds WIDTH bits. Define x = {frame_i, hist}, so x[j] for j < WIDTH is hist[j], and x[WIDTH + j] is frame_i[j].
- **Descramble function.** For each bit i: out[i] = frame_i[i] XOR (XOR over every delay k with TAP_MASK[k-1] = 1 of x[WIDTH + i − k]).
- **Descrambled frame.** When in_valid_i = 1 and descramble_en_i = 1:
  - data_o <= out
  - hist <= frame_i
  - sync_cnt increments
- **Bypass frame.** When in_valid_i = 1 and descramble_en_i = 0:
  - data_o <= frame_i
  - hist is unchanged
  - sync_cnt is unchanged
- **No frame.** When in_valid_i = 0: data_o, hist and sync_cnt hold, and valid_o <= 0.
- **FSM states.** The FSM has two states, PRIME and RUN.
  - PRIME: synced_o = 0. When a descrambled frame is accepted with sync_cnt = SYNC_FRAMES − 1, the FSM moves to RUN.
  - RUN: synced_o = 1. The FSM stays in RUN until reset or resync.
- **Output during PRIME.** Frames accepted in PRIME are still output with valid_o = 1. Consumers qualify them with synced_o.
- **resync_i = 1.** Has priority over everything else in the same cycle:
  - hist <= INIT
  - sync_cnt <= 0
  - FSM <= PRIME
  - valid_o <= 0
  - A coincident input frame is dropped and not counted.
  - data_o holds.
  - frame_cnt_o is not cleared.
- **Frame counter.** frame_cnt_o increments with each valid_o pulse and saturates at 0xFFFF.
- **Reset values.** All apply asynchronously while reset = 0:
  - hist = INIT
  - data_o = 0
  - valid_o = 0
  - synced_o = 0
  - frame_cnt_o = 0
  - sync_cnt = 0
  - FSM = PRIME
- **Reset mid-frame.** An in-flight frame is discarded, with no valid_o pulse after reset is released.
- **Parameter checks.** Elaboration fails (generate-time error) if:
  - TAP_MASK is 0, or
  - any TAP_MASK bit above WIDTH − 1 is set.

## Timing
- **Latency.** One cycle: a frame accepted at edge n appears on data_o/valid_o after edge n.
- **Throughput.** One frame per cycle; back-to-back in_valid_i is supported with no bubbles.
- **synced_o.** Asserts in the same cycle as the valid_o of the SYNC_FRAMES-th descrambled frame.
- **Register boundary.** The XOR tree is purely combinational from frame_i and hist to the data_o register. There is no combinational path from inputs to outputs.
- **Bypass and history.** Bypass frames do not advance history. The first descrambled frame after a bypass run therefore uses the last descrambled frame as history.

## Test plan
- **Reset output.** Defaults, reset then release; one descrambled frame 0x00000000 -> data_o = 0x3FFF8000, valid_o = 1, synced_o = 1, frame_cnt_o = 1.
- **Second frame after reset.** A second frame of 0x00000000 -> data_o = 0x00000000.
- **Round trip.** 1000 random frames scrambled by the matching reference scrambler model (same TAP_MASK, same INIT seed) -> data_o equals the original data on every frame; no bubbles with continuous in_valid_i.
- **Bypass.** descramble_en_i = 0, frame_i = 0x12345678 -> data_o = 0x12345678, hist unchanged. The next descrambled frame matches the model using the pre-bypass history.
- **Resync collision.** resync_i coincident with in_valid_i -> no valid_o, frame_cnt_o unchanged, synced_o = 0. With SYNC_FRAMES = 3, synced_o rises on the third subsequent descrambled frame.
- **Counter saturation and reset mid-stream.**
  - Force 0xFFFF frames -> frame_cnt_o holds at 0xFFFF on further frames.
  - Assert reset mid-stream -> all outputs are 0 immediately and the first valid_o appears only after a new frame is accepted.
- **Generic width.** WIDTH = 16, TAP_MASK with delays 3 and 16 -> round trip against the model passes.
